// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and the parity rule
// used by both the transmit and receive halves.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int INDEX_W   = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Even parity makes the total count of ones even; odd flips that.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: free-runs 0..CLKS_PER_BIT-1 and flags a chosen phase of the bit.
// The transmitter ticks on the last cycle; the receiver picks the half-bit phase.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TICK_AT      = CLKS_PER_BIT - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_bit_end,
  output logic o_pre_end
);

  localparam int W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PRE_AT  = (TICK_AT == 0) ? CLKS_PER_BIT - 1 : TICK_AT - 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] TICK = W'(TICK_AT);
  localparam logic [W-1:0] PRE  = W'(PRE_AT);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + W'(1);
    end
  end

  // o_pre_end lets a caller register an output that must line up with o_bit_end.
  assign o_bit_end = (r_count == TICK);
  assign o_pre_end = (r_count == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// All outputs come straight from registers.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TX_start,
  input  logic [7:0] DATA_in,
  output logic       tx,
  output logic       TX_busy,
  output logic       tx_done
);

  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(DATA_BITS - 1);
  localparam logic               ODD        = (PARITY_ODD != 0);

  logic [2:0]           r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [INDEX_W-1:0]   r_index;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  logic w_idle;
  logic w_bit_end;
  logic w_pre_end;

  assign w_idle = (r_state == S_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .TICK_AT     (CLKS_PER_BIT - 1)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_idle),
    .o_bit_end(w_bit_end),
    .o_pre_end(w_pre_end)
  );

  // tx is loaded one edge ahead of each bit window so the line never sees a
  // combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_index  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_STOP) && w_pre_end;
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (TX_start) begin
            r_shift  <= DATA_in;
            r_parity <= parity_bit(DATA_in, ODD);
            r_index  <= '0;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_index == LAST_INDEX) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_index <= r_index + INDEX_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign TX_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (even parity, odd parity, no parity) checked
// cycle by cycle against a frame model built from the bit-window rules.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] startV;
  logic [7:0] din0, din1, din2;
  wire        tx0, tx1, tx2;
  wire        busy0, busy1, busy2;
  wire        done0, done1, done2;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .TX_start(startV[0]), .DATA_in(din0),
    .tx(tx0), .TX_busy(busy0), .tx_done(done0));

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .TX_start(startV[1]), .DATA_in(din1),
    .tx(tx1), .TX_busy(busy1), .tx_done(done1));

  uart_tx #(.CLKS_PER_BIT(3), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
    .clk(clk), .rst(rst), .TX_start(startV[2]), .DATA_in(din2),
    .tx(tx2), .TX_busy(busy2), .tx_done(done2));

  function automatic int cpbOf(input int inst);
    return (inst == 2) ? 3 : 4;
  endfunction

  function automatic int penOf(input int inst);
    return (inst == 2) ? 0 : 1;
  endfunction

  function automatic int oddOf(input int inst);
    return (inst == 1) ? 1 : 0;
  endfunction

  function automatic int frameLen(input int inst);
    return (10 + penOf(inst)) * cpbOf(inst);
  endfunction

  // Line level expected cyc cycles after the start bit begins.
  function automatic logic expBit(input int inst, input logic [7:0] data, input int cyc);
    int b;
    b = cyc / cpbOf(inst);
    if (b == 0) return 1'b0;
    if (b <= 8) return data[b-1];
    if (penOf(inst) == 1 && b == 9) return logic'((($countones(data) + oddOf(inst)) % 2) != 0);
    return 1'b1;
  endfunction

  function automatic logic [2:0] obs(input int inst);
    case (inst)
      0:       return {tx0, busy0, done0};
      1:       return {tx1, busy1, done1};
      default: return {tx2, busy2, done2};
    endcase
  endfunction

  task automatic set_din(input int inst, input logic [7:0] v);
    case (inst)
      0:       din0 = v;
      1:       din1 = v;
      default: din2 = v;
    endcase
  endtask

  // Caller must be mid-cycle with the instance idle; returns mid-cycle in the idle gap.
  task automatic run_frame(input int inst, input logic [7:0] data, input bit hold,
                           input int changeAt, input logic [7:0] changeVal, input string name);
    int         len;
    int         cpb;
    int         b;
    logic [7:0] decoded;
    logic [2:0] o;
    logic [2:0] e;
    len     = frameLen(inst);
    cpb     = cpbOf(inst);
    decoded = 8'h00;
    startV[inst] = 1'b1;
    set_din(inst, data);
    @(posedge clk);
    for (int cyc = 0; cyc < len; cyc++) begin
      @(negedge clk);
      if (cyc == 0 && !hold) startV[inst] = 1'b0;
      if (cyc == changeAt) set_din(inst, changeVal);
      o = obs(inst);
      e = {expBit(inst, data, cyc), 1'b1, (cyc == len - 1)};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL %s cyc %0d: tx/busy/done got %b expected %b", name, cyc, o, e);
      end
      b = cyc / cpb;
      if (b >= 1 && b <= 8 && (cyc % cpb) == cpb / 2) decoded[b-1] = o[2];
    end
    checks++;
    if (decoded !== data) begin
      errors++;
      $display("[TB] FAIL %s decode: line carried %h expected %h", name, decoded, data);
    end
    @(negedge clk);
    o = obs(inst);
    checks++;
    if (o !== 3'b100) begin
      errors++;
      $display("[TB] FAIL %s idle gap: tx/busy/done got %b expected 100", name, o);
    end
  endtask

  task automatic test_reset();
    logic [2:0] o;
    rst    = 1'b0;
    startV = 3'b111;
    din0   = 8'hFF;
    din1   = 8'hFF;
    din2   = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      o = obs(i);
      checks++;
      if (o !== 3'b100) begin
        errors++;
        $display("[TB] FAIL reset inst %0d: tx/busy/done got %b expected 100", i, o);
      end
    end
    startV = 3'b000;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      o = obs(i);
      checks++;
      if (o !== 3'b100) begin
        errors++;
        $display("[TB] FAIL idle after reset inst %0d: got %b expected 100", i, o);
      end
    end
  endtask

  task automatic test_directed_frames();
    run_frame(0, 8'hDD, 1'b0, -1, 8'h00, "even_DD");
    run_frame(1, 8'hD0, 1'b0, -1, 8'h00, "odd_D0");
    run_frame(0, 8'hD0, 1'b0, -1, 8'h00, "even_D0");
    run_frame(2, 8'hD5, 1'b0, -1, 8'h00, "nopar_D5");
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    int         at;
    for (int inst = 0; inst < 3; inst++) begin
      for (int n = 0; n < 5; n++) begin
        d  = 8'($urandom);
        at = (n % 2 == 1) ? int'($urandom_range(0, frameLen(inst) - 1)) : -1;
        run_frame(inst, d, 1'b0, at, 8'($urandom), "random");
      end
    end
  endtask

  task automatic test_mid_frame_change();
    run_frame(0, 8'hDD, 1'b0, 3 * 4 + 1, 8'h00, "mid_change");
  endtask

  task automatic test_back_to_back();
    run_frame(0, 8'hDD, 1'b1, -1, 8'h00, "b2b_DD");
    run_frame(0, 8'hD2, 1'b1, -1, 8'h00, "b2b_D2");
    run_frame(0, 8'hD0, 1'b1, -1, 8'h00, "b2b_D0");
    run_frame(0, 8'hD5, 1'b1, -1, 8'h00, "b2b_D5");
    startV[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
    end
    run_frame(2, 8'($urandom), 1'b1, -1, 8'h00, "b2b_nopar_a");
    run_frame(2, 8'($urandom), 1'b1, -1, 8'h00, "b2b_nopar_b");
    startV[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] o;
    startV[0] = 1'b1;
    din0      = 8'hDD;
    @(posedge clk);
    for (int cyc = 0; cyc <= 4 * 4 + 1; cyc++) begin
      @(negedge clk);
      if (cyc == 0) startV[0] = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    o = obs(0);
    checks++;
    if (o !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset mid-frame: tx/busy/done got %b expected 100", o);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      o = obs(0);
      checks++;
      if (o !== 3'b100) begin
        errors++;
        $display("[TB] FAIL after reset release %0d: got %b expected 100", i, o);
      end
    end
    run_frame(0, 8'hDD, 1'b0, -1, 8'h00, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed_frames();
    test_random_frames();
    test_mid_frame_change();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
